// File: rtl/br_pred_unit.sv
// Branch predictor and resolver: bimodal BHT of saturating counters plus a
// resolve stage that issues registered fetch redirects. Optional statistics
// counters are compiled in with macro BR_PRED_STATS_EN.
module br_pred_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CNT_W     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pred_pc,
  output logic            pred_taken,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic [2:0]      res_op,
  input  logic [XLEN-1:0] res_a,
  input  logic [XLEN-1:0] res_b,
  input  logic [15:0]     res_imm16,
  input  logic [25:0]     res_index26,
  input  logic            res_pred,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef BR_PRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BLEZ = 3'b011;
  localparam logic [2:0] OP_BGTZ = 3'b100;
  localparam logic [2:0] OP_BLTZ = 3'b101;
  localparam logic [2:0] OP_BGEZ = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;

  // Elaboration-time parameter guards
  if (XLEN < 32) begin : g_bad_xlen
    $error("br_pred_unit: XLEN must be 32 or greater");
  end
  if ((BHT_DEPTH < 2) || ((BHT_DEPTH & (BHT_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("br_pred_unit: BHT_DEPTH must be a power of two, 2 or greater");
  end
  if ((CNT_W < 1) || (CNT_W > 4)) begin : g_bad_cnt_w
    $error("br_pred_unit: CNT_W must be 1 to 4");
  end

  logic [CNT_W-1:0] bht [BHT_DEPTH];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             unused_pred_bits;

  logic             a_neg;
  logic             a_zero;
  logic             a_eq_b;
  logic             is_cond;
  logic             is_jump;
  logic             taken;

  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  br_offset;
  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  jmp_target;
  logic [XLEN-1:0]  redirect_target_c;
  logic             mispredict_c;

  logic             update_en;
  logic [CNT_W-1:0] cur_cnt;
  logic [CNT_W-1:0] cnt_next;

  // Lookup: word-aligned PC bits select a counter; its MSB is the prediction
  assign pred_idx         = pred_pc[IDX_W+1:2];
  assign res_idx          = res_pc[IDX_W+1:2];
  assign pred_taken       = bht[pred_idx][CNT_W-1];
  assign unused_pred_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0]};

  assign a_neg  = res_a[XLEN-1];
  assign a_zero = (res_a == '0);
  assign a_eq_b = (res_a == res_b);

  // Opcode decode and branch outcome
  always_comb begin
    is_cond = 1'b0;
    is_jump = 1'b0;
    taken   = 1'b0;
    case (res_op)
      OP_BEQ:  begin is_cond = 1'b1; taken = a_eq_b;           end
      OP_BNE:  begin is_cond = 1'b1; taken = !a_eq_b;          end
      OP_BLEZ: begin is_cond = 1'b1; taken = a_neg || a_zero;  end
      OP_BGTZ: begin is_cond = 1'b1; taken = !a_neg && !a_zero; end
      OP_BLTZ: begin is_cond = 1'b1; taken = a_neg;            end
      OP_BGEZ: begin is_cond = 1'b1; taken = !a_neg;           end
      OP_J:    is_jump = 1'b1;
      OP_NONE: ;
      default: ;
    endcase
  end

  // Target generation, all arithmetic modulo 2^XLEN
  assign pc_plus4   = res_pc + XLEN'(4);
  assign br_offset  = {{(XLEN-18){res_imm16[15]}}, res_imm16, 2'b00};
  assign br_target  = pc_plus4 + br_offset;
  assign jmp_target = {pc_plus4[XLEN-1:28], res_index26, 2'b00};

  assign mispredict_c = res_valid && ((is_cond && (taken != res_pred)) || is_jump);

  always_comb begin
    redirect_target_c = pc_plus4;
    if (is_jump) begin
      redirect_target_c = jmp_target;
    end else if (taken) begin
      redirect_target_c = br_target;
    end
  end

  // Saturating counter next value for the resolving index
  assign update_en = res_valid && is_cond;
  assign cur_cnt   = bht[res_idx];

  always_comb begin
    cnt_next = cur_cnt;
    if (taken) begin
      if (cur_cnt != CNT_MAX) begin
        cnt_next = cur_cnt + CNT_W'(1);
      end
    end else if (cur_cnt != '0) begin
      cnt_next = cur_cnt - CNT_W'(1);
    end
  end

  // Counter table; lookups see the pre-update value in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (update_en) begin
      bht[res_idx] <= cnt_next;
    end
  end

  // Redirect is a one-cycle pulse; the PC holds between redirects
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict_c;
      if (mispredict_c) begin
        redirect_pc <= redirect_target_c;
      end
    end
  end

`ifdef BR_PRED_STATS_EN
  // Event counters, wrapping modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (update_en) begin
        stat_branches <= stat_branches + 32'(1);
      end
      if (mispredict_c) begin
        stat_mispredicts <= stat_mispredicts + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_br_pred_unit.sv
// Directed self-checking bench for br_pred_unit (default parameters, stats disabled).
module tb_br_pred_unit;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_BEQ  = 3'b001;
  localparam logic [2:0] OP_BNE  = 3'b010;
  localparam logic [2:0] OP_BLEZ = 3'b011;
  localparam logic [2:0] OP_BGTZ = 3'b100;
  localparam logic [2:0] OP_BLTZ = 3'b101;
  localparam logic [2:0] OP_BGEZ = 3'b110;
  localparam logic [2:0] OP_J    = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  res_op;
  logic [31:0] res_a;
  logic [31:0] res_b;
  logic [15:0] res_imm16;
  logic [25:0] res_index26;
  logic        res_pred;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  br_pred_unit #(.XLEN(32), .BHT_DEPTH(16), .CNT_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .res_valid      (res_valid),
    .res_pc         (res_pc),
    .res_op         (res_op),
    .res_a          (res_a),
    .res_b          (res_b),
    .res_imm16      (res_imm16),
    .res_index26    (res_index26),
    .res_pred       (res_pred),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
    pred_pc = pc;
    #1;
    check(tag, pred_taken, exp);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input logic [25:0] idx,
                       input logic pred);
    res_op      = op;
    res_pc      = pc;
    res_a       = a;
    res_b       = b;
    res_imm16   = imm;
    res_index26 = idx;
    res_pred    = pred;
    res_valid   = 1'b1;
  endtask

  // Present one resolve for one edge, return at the following negedge
  task automatic resolve(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm, input logic [25:0] idx,
                         input logic pred);
    drive(op, pc, a, b, imm, idx, pred);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pred_pc = 32'h40;
    drive(OP_NONE, 32'h0, 32'h0, 32'h0, 16'h0, 26'h0, 1'b0);
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rv", redirect_valid, 1'b0);
    check("rst_rpc", redirect_pc, 32'h0);
    peek("rst_pred", 32'h40, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // BEQ taken, predicted not-taken
    resolve(OP_BEQ, 32'h100, 32'd5, 32'd5, 16'h0004, 26'h0, 1'b0);
    check("beq_rv", redirect_valid, 1'b1);
    check("beq_rpc", redirect_pc, 32'h114);
    @(negedge clk);
    check("beq_rv_clear", redirect_valid, 1'b0);
    check("beq_rpc_hold", redirect_pc, 32'h114);

    // BNE taken, backward offset; then correctly predicted
    resolve(OP_BNE, 32'h200, 32'd1, 32'd2, 16'hFFFF, 26'h0, 1'b0);
    check("bne_rv", redirect_valid, 1'b1);
    check("bne_rpc", redirect_pc, 32'h200);
    resolve(OP_BNE, 32'h200, 32'd1, 32'd2, 16'hFFFF, 26'h0, 1'b1);
    check("bne_ok_rv", redirect_valid, 1'b0);
    check("bne_ok_rpc_hold", redirect_pc, 32'h200);

    // Signed compares against zero
    resolve(OP_BLTZ, 32'h300, 32'h8000_0000, 32'h0, 16'h0001, 26'h0, 1'b0);
    check("bltz_rv", redirect_valid, 1'b1);
    check("bltz_rpc", redirect_pc, 32'h308);
    resolve(OP_BGEZ, 32'h304, 32'h8000_0000, 32'h0, 16'h0001, 26'h0, 1'b0);
    check("bgez_rv", redirect_valid, 1'b0);
    resolve(OP_BLEZ, 32'h10, 32'h0, 32'h0, 16'h0002, 26'h0, 1'b0);
    check("blez_rv", redirect_valid, 1'b1);
    check("blez_rpc", redirect_pc, 32'h1C);
    resolve(OP_BGTZ, 32'h20, 32'h0, 32'h0, 16'h0002, 26'h0, 1'b1);
    check("bgtz_rv", redirect_valid, 1'b1);
    check("bgtz_rpc", redirect_pc, 32'h24);
    peek("blez_cnt_up", 32'h10, 1'b1);
    peek("bgtz_cnt_dn", 32'h20, 1'b0);
    peek("bgez_cnt_dn", 32'h304, 1'b0);

    // NONE leaves everything alone
    resolve(OP_NONE, 32'h10, 32'h0, 32'h0, 16'h0, 26'h0, 1'b1);
    check("none_rv", redirect_valid, 1'b0);
    peek("none_cnt", 32'h10, 1'b1);

    // Jump always redirects
    resolve(OP_J, 32'h0040_0000, 32'h0, 32'h0, 16'h0, 26'h10, 1'b1);
    check("j_rv", redirect_valid, 1'b1);
    check("j_rpc", redirect_pc, 32'h40);

    // Reset restores counters to weakly not-taken
    rst = 1'b1;
    @(negedge clk);
    peek("rst2_cnt", 32'h10, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    resolve(OP_J, 32'h0040_0000, 32'h0, 32'h0, 16'h0, 26'h10, 1'b0);
    check("j2_rv", redirect_valid, 1'b1);
    check("j2_rpc", redirect_pc, 32'h40);
    peek("j_no_cnt", 32'h40, 1'b0);

    // Four back-to-back taken BNE at 0x40, first one also checks no bypass
    drive(OP_BNE, 32'h40, 32'd1, 32'd2, 16'h0, 26'h0, 1'b1);
    peek("no_bypass", 32'h40, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(OP_BNE, 32'h40, 32'd1, 32'd2, 16'h0, 26'h0, 1'b1);
      @(negedge clk);
      check("b2b_rv", redirect_valid, 1'b0);
    end
    res_valid = 1'b0;
    peek("train_40", 32'h40, 1'b1);
    peek("alias_80", 32'h80, 1'b1);
    resolve(OP_BNE, 32'h40, 32'd3, 32'd3, 16'h0, 26'h0, 1'b1);
    check("nt_rv", redirect_valid, 1'b1);
    check("nt_rpc", redirect_pc, 32'h44);
    peek("hyst_40", 32'h40, 1'b1);

    // Reset right after a mispredicting resolve discards the redirect
    drive(OP_BEQ, 32'h100, 32'd5, 32'd5, 16'h0004, 26'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    res_valid = 1'b0;
    @(negedge clk);
    check("rstpend_rv", redirect_valid, 1'b0);
    check("rstpend_rpc", redirect_pc, 32'h0);
    peek("rstpend_cnt", 32'h40, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstpend_rv2", redirect_valid, 1'b0);

    // Resolve coinciding with reset is ignored
    rst = 1'b1;
    drive(OP_BEQ, 32'h100, 32'd5, 32'd5, 16'h0004, 26'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    res_valid = 1'b0;
    @(negedge clk);
    check("rstcoin_rv", redirect_valid, 1'b0);
    peek("rstcoin_cnt", 32'h40, 1'b0);

    // Back-to-back mispredicts each redirect
    drive(OP_BEQ, 32'h100, 32'd5, 32'd5, 16'h0004, 26'h0, 1'b0);
    @(negedge clk);
    check("b2b_mp1_rv", redirect_valid, 1'b1);
    check("b2b_mp1_rpc", redirect_pc, 32'h114);
    drive(OP_BNE, 32'h200, 32'd1, 32'd2, 16'hFFFF, 26'h0, 1'b0);
    @(negedge clk);
    res_valid = 1'b0;
    check("b2b_mp2_rv", redirect_valid, 1'b1);
    check("b2b_mp2_rpc", redirect_pc, 32'h200);
    @(negedge clk);
    check("b2b_mp_end_rv", redirect_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
